// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART for the core's IO window: TX/RX byte FIFOs, STATUS and BAUD
// registers, registered read data that is zero when not selected.
module uart_bus_responder #(
  parameter int BUS_ADDR_DATA_LEN = 13,
  parameter int BASE_ADDR         = 'h20,
  parameter int FIFO_DEPTH_LOG2   = 4,
  parameter int DEFAULT_BAUD_DIV  = 925
) (
  input  logic                         rst,
  input  logic                         clk,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  input  logic                         wr_dat,
  input  logic                         rd_dat,
  input  logic [31:0]                  bus_dat_in,
  output logic [31:0]                  bus_dat_out,
  output logic                         uart_tx,
  input  logic                         uart_rx,
  output logic                         irq
);

  localparam int AW    = BUS_ADDR_DATA_LEN - 2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [AW-1:0] A_TXDATA = AW'((BASE_ADDR >> 2) + 0);
  localparam logic [AW-1:0] A_RXDATA = AW'((BASE_ADDR >> 2) + 1);
  localparam logic [AW-1:0] A_STATUS = AW'((BASE_ADDR >> 2) + 2);
  localparam logic [AW-1:0] A_BAUD   = AW'((BASE_ADDR >> 2) + 3);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [7:0]    r_rx_mem [DEPTH];
  logic [PW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [15:0]   r_baud;
  logic          r_rx_ovr, r_ferr, r_tx_ovf;
  tx_state_t     r_tx_state;
  logic [15:0]   r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  rx_state_t     r_rx_state;
  logic [15:0]   r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_s1, r_rx_s2, r_rx_d;

  logic [AW-1:0] w_word;
  logic          w_sel_tx, w_sel_rx, w_sel_st, w_sel_bd;
  logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full, w_tx_idle;
  logic          w_tx_push, w_tx_pop, w_tx_ovf, w_tx_tick;
  logic          w_rx_push, w_rx_pop, w_rx_ovr, w_rx_ferr, w_rx_done, w_rx_tick, w_rx_fall;
  logic [16:0]   w_baud_p1;
  logic [31:0]   w_rd_data;
  logic          w_unused;

  assign w_word   = addr_dat[BUS_ADDR_DATA_LEN-1:2];
  assign w_sel_tx = (w_word == A_TXDATA);
  assign w_sel_rx = (w_word == A_RXDATA);
  assign w_sel_st = (w_word == A_STATUS);
  assign w_sel_bd = (w_word == A_BAUD);
  assign w_unused = ^{bus_dat_in[31:16], addr_dat[1:0], w_baud_p1[0]};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_tx_empty = (r_tx_wr == r_tx_rd);
  assign w_tx_full  = (r_tx_wr[PW-1] != r_tx_rd[PW-1]) && (r_tx_wr[PW-2:0] == r_tx_rd[PW-2:0]);
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[PW-1] != r_rx_rd[PW-1]) && (r_rx_wr[PW-2:0] == r_rx_rd[PW-2:0]);
  assign w_tx_idle  = w_tx_empty && (r_tx_state == TX_IDLE);

  assign w_tx_tick = (r_tx_cnt == 16'd0);
  assign w_tx_push = wr_dat && w_sel_tx && !w_tx_full;
  assign w_tx_ovf  = wr_dat && w_sel_tx && w_tx_full;
  assign w_tx_pop  = !w_tx_empty &&
                     ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_tick));

  assign w_rx_tick = (r_rx_cnt == 16'd0);
  assign w_rx_fall = r_rx_d && !r_rx_s2;
  assign w_rx_done = (r_rx_state == RX_STOP) && w_rx_tick;
  assign w_rx_push = w_rx_done && r_rx_s2 && !w_rx_full;
  assign w_rx_ovr  = w_rx_done && r_rx_s2 && w_rx_full;
  assign w_rx_ferr = w_rx_done && !r_rx_s2;
  assign w_rx_pop  = wr_dat && w_sel_rx && !w_rx_empty;
  assign w_baud_p1 = {1'b0, r_baud} + 17'd1;

  assign irq = !w_rx_empty;

  always_comb begin
    w_rd_data = '0;
    if (rd_dat) begin
      if (w_sel_rx && !w_rx_empty)
        w_rd_data = {1'b1, 23'd0, r_rx_mem[r_rx_rd[PW-2:0]]};
      else if (w_sel_st)
        w_rd_data = {26'd0, r_tx_ovf, r_ferr, r_rx_ovr, !w_rx_empty, w_tx_idle, w_tx_full};
      else if (w_sel_bd)
        w_rd_data = {16'd0, r_baud};
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[PW-2:0]] <= bus_dat_in[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr[PW-2:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wr     <= '0;
      r_tx_rd     <= '0;
      r_rx_wr     <= '0;
      r_rx_rd     <= '0;
      r_baud      <= 16'(DEFAULT_BAUD_DIV);
      r_rx_ovr    <= 1'b0;
      r_ferr      <= 1'b0;
      r_tx_ovf    <= 1'b0;
      bus_dat_out <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + PW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + PW'(1);
      if (w_rx_push) r_rx_wr <= r_rx_wr + PW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + PW'(1);
      if (wr_dat && w_sel_bd) r_baud <= bus_dat_in[15:0];
      // A flag event in the same cycle as a clear-write wins over the clear.
      if (wr_dat && w_sel_st) begin
        if (bus_dat_in[3]) r_rx_ovr <= 1'b0;
        if (bus_dat_in[4]) r_ferr   <= 1'b0;
        if (bus_dat_in[5]) r_tx_ovf <= 1'b0;
      end
      if (w_rx_ovr)  r_rx_ovr <= 1'b1;
      if (w_rx_ferr) r_ferr   <= 1'b1;
      if (w_tx_ovf)  r_tx_ovf <= 1'b1;
      bus_dat_out <= w_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      uart_tx    <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (w_tx_pop) begin
          r_tx_shift <= r_tx_mem[r_tx_rd[PW-2:0]];
          uart_tx    <= 1'b0;
          r_tx_cnt   <= r_baud;
          r_tx_state <= TX_START;
        end
        TX_START: if (w_tx_tick) begin
          uart_tx    <= r_tx_shift[0];
          r_tx_cnt   <= r_baud;
          r_tx_bit   <= 3'd0;
          r_tx_state <= TX_DATA;
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        TX_DATA: if (w_tx_tick) begin
          r_tx_cnt <= r_baud;
          if (r_tx_bit == 3'd7) begin
            uart_tx    <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            uart_tx    <= r_tx_shift[1];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
          end
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        TX_STOP: if (w_tx_tick) begin
          // Chain straight into the next start bit when a byte is waiting.
          if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rd[PW-2:0]];
            uart_tx    <= 1'b0;
            r_tx_cnt   <= r_baud;
            r_tx_state <= TX_START;
          end else r_tx_state <= TX_IDLE;
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: if (w_rx_fall) begin
          r_rx_cnt   <= w_baud_p1[16:1];
          r_rx_state <= RX_START;
        end
        RX_START: if (w_rx_tick) begin
          if (r_rx_s2) r_rx_state <= RX_IDLE;
          else begin
            r_rx_cnt   <= r_baud;
            r_rx_bit   <= 3'd0;
            r_rx_state <= RX_DATA;
          end
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        RX_DATA: if (w_rx_tick) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_cnt   <= r_baud;
          r_rx_bit   <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        RX_STOP: if (w_rx_tick) r_rx_state <= r_rx_s2 ? RX_IDLE : RX_BREAK;
        else r_rx_cnt <= r_rx_cnt - 16'd1;
        RX_BREAK: if (r_rx_s2) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder: register access, TX framing, RX capture,
// FIFO limits, sticky flags and asynchronous reset.
module tb_uart_bus_responder;

  localparam logic [12:0] A_TX = 13'h20, A_RX = 13'h24, A_ST = 13'h28, A_BD = 13'h2C;

  logic        rst, clk, wr_dat, rd_dat, uart_rx, uart_tx, irq;
  logic [12:0] addr_dat;
  logic [31:0] bus_dat_in, bus_dat_out;
  int          n_chk = 0;
  int          n_bad = 0;

  uart_bus_responder dut (
    .rst(rst), .clk(clk), .addr_dat(addr_dat), .wr_dat(wr_dat), .rd_dat(rd_dat),
    .bus_dat_in(bus_dat_in), .bus_dat_out(bus_dat_out), .uart_tx(uart_tx),
    .uart_rx(uart_rx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [12:0] a, input logic [31:0] d);
    addr_dat = a; bus_dat_in = d; wr_dat = 1'b1;
    tick();
    wr_dat = 1'b0;
  endtask

  task automatic bus_rd(input logic [12:0] a, output logic [31:0] d);
    addr_dat = a; rd_dat = 1'b1;
    tick();
    rd_dat = 1'b0;
    d = bus_dat_out;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, input int per);
    uart_rx = 1'b0;
    repeat (per) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (per) tick();
    end
    uart_rx = stopb;
    repeat (per) tick();
    uart_rx = 1'b1;
  endtask

  task automatic recv_tx(input int per, output logic [7:0] b, output logic ok);
    int   n;
    logic st_lo, sp_hi;
    n = 0; b = '0; ok = 1'b0;
    while (uart_tx !== 1'b0 && n < 4000) begin
      tick();
      n++;
    end
    if (uart_tx !== 1'b0) return;
    repeat (per / 2) tick();
    st_lo = (uart_tx == 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (per) tick();
      b[i] = uart_tx;
    end
    repeat (per) tick();
    sp_hi = uart_tx;
    ok = st_lo && sp_hi;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [39:0] obs, expv;
    logic [9:0]  fr;
    int          n;

    rst = 1'b0; wr_dat = 1'b0; rd_dat = 1'b0; addr_dat = '0; bus_dat_in = '0; uart_rx = 1'b1;
    repeat (3) tick();
    chk("rst_tx", uart_tx, 1);
    chk("rst_irq", irq, 0);
    chk("rst_dout", bus_dat_out, 0);
    rst = 1'b1;
    bus_rd(A_ST, rd); chk("rst_status", rd, 32'h02);
    bus_rd(A_BD, rd); chk("rst_baud", rd, 925);

    // TX frame 0xA5 at 4 clocks per bit
    bus_wr(A_BD, 3);
    bus_rd(A_BD, rd); chk("baud3", rd, 3);
    bus_wr(A_TX, 32'hA5);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) expv[i] = fr[i / 4];
    n = 0;
    while (uart_tx !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    obs[0] = uart_tx;
    for (int i = 1; i < 40; i++) begin
      tick();
      obs[i] = uart_tx;
    end
    chk("t1_frame", obs, expv);
    bus_rd(A_ST, rd); chk("t1_stop_busy", rd, 32'h00);
    bus_rd(A_ST, rd); chk("t1_idle", rd, 32'h02);

    // 17 queued bytes, 18th overflows; decode the line concurrently
    bus_wr(A_BD, 31);
    fork
      begin
        for (int i = 0; i < 17; i++) bus_wr(A_TX, i);
        bus_rd(A_ST, rd); chk("t2_full", rd, 32'h01);
        bus_wr(A_TX, 32'h11);
        bus_rd(A_ST, rd); chk("t2_ovf", rd, 32'h21);
      end
      begin
        logic [7:0] b;
        logic       ok;
        for (int f = 0; f < 17; f++) begin
          recv_tx(32, b, ok);
          chk("t2_byte", {ok, b}, {1'b1, 8'(f)});
        end
      end
    join
    repeat (20) tick();
    bus_rd(A_ST, rd); chk("t2_done", rd, 32'h22);
    bus_wr(A_ST, 32'h20);
    bus_rd(A_ST, rd); chk("t2_clr", rd, 32'h02);

    // RX frame 0x3C at 8 clocks per bit
    bus_wr(A_BD, 7);
    send_rx(8'h3C, 1'b1, 8);
    repeat (2) tick();
    chk("t3_irq", irq, 1);
    bus_rd(A_RX, rd); chk("t3_rxdata", rd, 32'h8000003C);
    bus_wr(A_RX, 0);
    chk("t3_irq_off", irq, 0);
    bus_rd(A_RX, rd); chk("t3_empty", rd, 32'h0);

    // Framing error, clear, then a short glitch
    send_rx(8'h55, 1'b0, 8);
    repeat (4) tick();
    chk("t4_irq", irq, 0);
    bus_rd(A_ST, rd); chk("t4_ferr", rd, 32'h12);
    bus_wr(A_ST, 32'h10);
    bus_rd(A_ST, rd); chk("t4_clr", rd, 32'h02);
    uart_rx = 1'b0;
    repeat (2) tick();
    uart_rx = 1'b1;
    repeat (30) tick();
    chk("t4_glitch_irq", irq, 0);
    bus_rd(A_ST, rd); chk("t4_glitch", rd, 32'h02);

    // RX FIFO overrun: 17 frames, first 16 retained in order
    for (int i = 0; i < 17; i++) send_rx(8'h40 + 8'(i), 1'b1, 8);
    repeat (4) tick();
    bus_rd(A_ST, rd); chk("t5_ovr", rd, 32'h0E);
    for (int i = 0; i < 15; i++) begin
      bus_rd(A_RX, rd); chk("t5_order", rd, 32'h80000040 + 32'(i));
      bus_wr(A_RX, 0);
    end
    bus_rd(A_RX, rd); chk("t5_last", rd, 32'h8000004F);

    // Reset in the middle of a TX data bit
    chk("t6_irq_pre", irq, 1);
    bus_wr(A_TX, 32'h00);
    repeat (14) tick();
    chk("t6_tx_pre", uart_tx, 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_tx_rst", uart_tx, 1);
    chk("t6_irq_rst", irq, 0);
    chk("t6_dout_rst", bus_dat_out, 0);
    tick();
    #2 rst = 1'b1;
    tick();
    bus_rd(A_ST, rd); chk("t6_status", rd, 32'h02);
    bus_rd(A_BD, rd); chk("t6_baud", rd, 925);
    bus_rd(13'h2F, rd); chk("t6_baud_lowbits", rd, 925);
    addr_dat = A_BD; rd_dat = 1'b0;
    tick();
    chk("t6_rd_off", bus_dat_out, 0);
    bus_rd(13'h30, rd); chk("t6_nomatch", rd, 0);
    bus_wr(13'h1C, 32'h5);
    bus_rd(A_BD, rd); chk("t6_baud_kept", rd, 925);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (uart_tx !== 1'b1) n++;
    end
    chk("t6_no_partial", n, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
- Memory-mapped 8N1 UART peripheral that responds to the RISC-V lite data-bus initiator on the IO window, alongside the PIO.
- Accepts register writes and reads from the core.
- Serialises TX bytes from a FIFO and deserialises RX bytes into a FIFO.
- Read data follows the synchronous-RAM timing the core expects; the output is zero when not selected, so it can be OR-combined in bus_dmux.

Parameters:
- BUS_ADDR_DATA_LEN, 13, width of addr_dat.
- BASE_ADDR, 'h20, byte address of register 0; must be 16-byte aligned.
- FIFO_DEPTH_LOG2, 4, log2 of TX and RX FIFO depth (16 entries each).
- DEFAULT_BAUD_DIV, 925, reset value of BAUD; bit period = BAUD+1 clk cycles (106.67 MHz / 115200).

Ports:
- rst  in  1  reset, asynchronous, active-low
- clk  in  1  core clock
- addr_dat  in  BUS_ADDR_DATA_LEN  byte address from core
- wr_dat  in  1  write strobe; one write per asserted cycle with a matching address
- rd_dat  in  1  peripheral select / read enable
- bus_dat_in  in  32  write data
- bus_dat_out  out  32  read data, registered
- uart_tx  out  1  serial out, idle high
- uart_rx  in  1  serial in, asynchronous
- irq  out  1  level: RX FIFO not empty

Behaviour:
- Register decode: addr_dat[BUS_ADDR_DATA_LEN-1:2] is compared with (BASE_ADDR>>2)+k; addr_dat[1:0] is ignored. Only a matching access has an effect.
- k=0 TXDATA (W): bus_dat_in[7:0] is pushed to the TX FIFO. If the FIFO is full, the write is dropped and TX_OVF is set.
- k=1 RXDATA:
  - Read returns [31]=RX not empty, [7:0]=FIFO head, other bits 0.
  - Any write pops the head; popping when empty has no effect.
- k=2 STATUS: [0] TX full, [1] TX idle (FIFO empty and shifter idle), [2] RX not empty, [3] RX_OVR sticky, [4] FRAME_ERR sticky, [5] TX_OVF sticky. Writing 1 to bits 3/4/5 clears them; other bits are read-only.
- k=3 BAUD (R/W): [15:0] divisor; upper bits read 0.
- Read timing: bus_dat_out is registered. The value for the address present in cycle N (rd_dat=1) appears in cycle N+1. When rd_dat=0 or the address does not match in cycle N, bus_dat_out=0 in N+1. Reads have no side effects.
- Simultaneous events: full/empty are evaluated on pre-cycle state.
  - A push into a full FIFO is rejected even if a pop occurs the same cycle.
  - A pop plus a push on a non-full FIFO both take effect.
- TX FSM, states IDLE→START→DATA→STOP→IDLE:
  - IDLE: if the FIFO is not empty, pop into the shifter, drive uart_tx=0, enter START.
  - Each state lasts BAUD+1 cycles.
  - DATA sends 8 bits LSB first.
  - STOP drives 1 for one bit period.
  - Back-to-back bytes have no extra idle bit.
- RX path: uart_rx passes through a 2-FF synchroniser, reset value 1.
- RX FSM, states IDLE→START→DATA→STOP:
  - IDLE: a synchronised falling edge starts a counter of (BAUD+1)>>1.
  - START: if the line is high at mid-bit, it is a false start; return to IDLE and store nothing.
  - DATA: 8 samples, each BAUD+1 cycles apart at mid-bit, LSB first.
  - STOP sample = 1 → push the byte. If the RX FIFO is full, drop the byte and set RX_OVR.
  - STOP sample = 0 → discard the byte, set FRAME_ERR, and wait for the line to return high before IDLE.
- BAUD written mid-frame: the new value is used from the next bit-period reload; the current bit finishes with the old count.
- BAUD=0: bit period is 1 cycle for TX; RX behaviour is unspecified below BAUD=3.
- FIFO pointers are FIFO_DEPTH_LOG2+1 bits wide, wrapping naturally. Full when the MSBs differ and the remaining bits are equal.
- Reset values (async, any cycle, including mid-frame):
  - uart_tx=1, bus_dat_out=0, irq=0.
  - FIFOs empty, both FSMs IDLE, sticky flags 0, BAUD=DEFAULT_BAUD_DIV.
  - A frame in progress is abandoned with no partial output after reset is released.

Test Plan:
1. BAUD=3; write TXDATA 0xA5 → uart_tx low for 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, then high 4 clks. STATUS[1] goes 1 after the stop bit.
2. Write 17 bytes 0x00..0x10 while TX is stalled (BAUD=0xFFFF) → the first is popped to the shifter and 16 are queued. The 17th is accepted only if the shifter has popped; otherwise STATUS[5]=1. Verify the count and data order on the line.
3. Drive RX frame 0x3C at BAUD=7 → irq=1. RXDATA read returns 0x8000003C one cycle after the address. Write RXDATA → irq=0, read returns 0x00000000.
4. RX frame with stop bit 0 → no push, STATUS[4]=1. Write STATUS 0x10 → bit clears. A 2-clk low glitch on RX → no byte stored.
5. Fill the RX FIFO with 16 frames, send a 17th → STATUS[3]=1, and the head is still the first byte.
6. Assert rst mid-TX data bit → uart_tx=1 immediately, STATUS reads 0x02, BAUD reads 925. Also check rd_dat=0 → bus_dat_out=0 next cycle.
